piso_serializer: RTL and testbench

- Parallel-in, serial-out byte shift register with valid/ready handshakes on both sides.
- It is the transmit-side counterpart of the parallel-out shift register.
- It accepts one DEPTH-byte word and emits it one byte per transfer.
- Its serial output can drive that register's column_shift_in directly. After DEPTH transfers, that register's p_out equals the original p_in.

---
 rtl/piso_serializer.sv | 117 +++++++++++
 tb/tb_piso_serializer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out byte serializer; valid/ready on both sides.
// Ports: clock, reset (async active-low), enable, p_valid/p_ready/p_in, s_valid/s_ready/s_data/s_last, busy. Macro PISO_LSB_FIRST_EN: byte 0 first.
module piso_serializer #(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [8*DEPTH-1:0] p_in,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [7:0]       s_data,
  output logic             s_last,
  output logic             busy
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("piso_serializer: DEPTH must be >= 1");
  end

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [8*DEPTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         s_data_q, s_data_d;
  logic               s_valid_q, s_valid_d;
  logic               s_last_q, s_last_d;
  logic               busy_q, busy_d;

  logic               p_acc;
  logic               s_xfer;
  logic [CNT_W-1:0]   cnt_nxt;

  // Emission slot c maps to a byte lane depending on order.
  function automatic logic [7:0] pick(
    input logic [8*DEPTH-1:0] w,
    input logic [CNT_W-1:0]   c
  );
    int k;
`ifdef PISO_LSB_FIRST_EN
    k = int'(c);
`else
    k = DEPTH - 1 - int'(c);
`endif
    return w[8*k +: 8];
  endfunction

  // Reload is allowed on the edge that consumes the last byte.
  assign p_ready = reset && enable &&
                   (state_q == IDLE ||
                    (s_valid_q && s_ready && s_last_q));
  assign p_acc   = enable && p_valid && p_ready;
  assign s_xfer  = enable && s_valid_q && s_ready;
  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    s_data_d  = s_data_q;
    s_valid_d = s_valid_q;
    s_last_d  = s_last_q;
    busy_d    = busy_q;
    if (p_acc) begin
      state_d   = SHIFT;
      word_d    = p_in;
      cnt_d     = '0;
      s_data_d  = pick(p_in, '0);
      s_valid_d = 1'b1;
      s_last_d  = (DEPTH == 1);
      busy_d    = 1'b1;
    end else if (state_q == SHIFT && s_xfer) begin
      if (cnt_q == LAST) begin
        state_d   = IDLE;
        s_valid_d = 1'b0;
        s_last_d  = 1'b0;
        busy_d    = 1'b0;
      end else begin
        cnt_d    = cnt_nxt;
        s_data_d = pick(word_q, cnt_nxt);
        s_last_d = (cnt_nxt == LAST);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      cnt_q     <= '0;
      s_data_q  <= 8'd0;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      s_data_q  <= s_data_d;
      s_valid_q <= s_valid_d;
      s_last_q  <= s_last_d;
      busy_q    <= busy_d;
    end
  end

  assign s_valid = s_valid_q;
  assign s_data  = s_data_q;
  assign s_last  = s_last_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with DEPTH=3.
// Inputs change and outputs are checked on the falling edge.
module tb_piso_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        p_valid;
  logic        p_ready;
  logic [23:0] p_in;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  piso_serializer #(.DEPTH(3)) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .p_valid (p_valid),
    .p_ready (p_ready),
    .p_in    (p_in),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .busy    (busy)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // i-th byte on the wire for word w.
  function automatic logic [7:0] nth(
    input logic [23:0] w,
    input int          i
  );
    logic [23:0] t;
    t = w;
`ifdef PISO_LSB_FIRST_EN
    return t[8*i +: 8];
`else
    return t[8*(2-i) +: 8];
`endif
  endfunction

  task automatic emit(
    input string       tag,
    input logic [23:0] w,
    input int          i
  );
    check({tag, ".valid"}, 32'(s_valid), 32'd1);
    check({tag, ".data"}, 32'(s_data), 32'(nth(w, i)));
    check({tag, ".last"}, 32'(s_last), 32'(i == 2));
    check({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic idle(input string tag);
    check({tag, ".valid"}, 32'(s_valid), 32'd0);
    check({tag, ".last"}, 32'(s_last), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic step;
    @(negedge clock);
  endtask

  initial begin
    reset   = 1'b0;
    enable  = 1'b1;
    p_valid = 1'b0;
    s_ready = 1'b0;
    p_in    = 24'h0;
    step;
    step;
    check("rst.p_ready", 32'(p_ready), 32'd0);
    idle("rst");
    reset = 1'b1;
    #1;
    check("rst.s_data", 32'(s_data), 32'd0);
    check("rst.p_ready_hi", 32'(p_ready), 32'd1);
    idle("rst_rel");

    // Single word
    p_in = 24'hCCBBAA; p_valid = 1'b1; s_ready = 1'b1;
    step; emit("one0", 24'hCCBBAA, 0); p_valid = 1'b0;
    step; emit("one1", 24'hCCBBAA, 1);
    check("one1.p_ready", 32'(p_ready), 32'd0);
    step; emit("one2", 24'hCCBBAA, 2);
    check("one2.p_ready", 32'(p_ready), 32'd1);
    step; idle("one_end");

    // Backpressure
    p_valid = 1'b1; s_ready = 1'b0;
    step; emit("bp0", 24'hCCBBAA, 0); p_valid = 1'b0;
    check("bp0.p_ready", 32'(p_ready), 32'd0);
    step; emit("bp1", 24'hCCBBAA, 0);
    check("bp1.p_ready", 32'(p_ready), 32'd0);
    step; emit("bp2", 24'hCCBBAA, 0); s_ready = 1'b1;
    step; emit("bp3", 24'hCCBBAA, 1);
    step; emit("bp4", 24'hCCBBAA, 2);
    step; idle("bp_end");

    // Back-to-back
    p_in = 24'h030201; p_valid = 1'b1;
    step; emit("b2b0", 24'h030201, 0); p_in = 24'h060504;
    step; emit("b2b1", 24'h030201, 1);
    check("b2b1.p_ready", 32'(p_ready), 32'd0);
    step; emit("b2b2", 24'h030201, 2);
    check("b2b2.p_ready", 32'(p_ready), 32'd1);
    step; emit("b2b3", 24'h060504, 0); p_valid = 1'b0;
    step; emit("b2b4", 24'h060504, 1);
    step; emit("b2b5", 24'h060504, 2);
    step; idle("b2b_end");

    // Enable stall then reset mid-word
    p_in = 24'hCCBBAA; p_valid = 1'b1;
    step; emit("en0", 24'hCCBBAA, 0); p_valid = 1'b0; enable = 1'b0;
    #1 check("en0.p_ready", 32'(p_ready), 32'd0);
    step; emit("en1", 24'hCCBBAA, 0);
    step; emit("en2", 24'hCCBBAA, 0); enable = 1'b1;
    step; emit("en3", 24'hCCBBAA, 1);
    reset = 1'b0;
    #1;
    idle("mid_rst");
    check("mid_rst.s_data", 32'(s_data), 32'd0);
    check("mid_rst.p_ready", 32'(p_ready), 32'd0);
    step;
    reset = 1'b1; p_in = 24'h030201; p_valid = 1'b1;
    #1 check("rel.p_ready", 32'(p_ready), 32'd1);
    step; emit("re0", 24'h030201, 0); p_valid = 1'b0;
    step; emit("re1", 24'h030201, 1);
    step; emit("re2", 24'h030201, 2);
    step; idle("re_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
